serial_rbs: RTL and testbench

- Bit-serial ripple-borrow subtractor. Computes in1 - in2 - borrow_in, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
- Sequential counterpart to the combinational ripple-carry adder in the arithmetic library.
- Area-cheap subtract datapath for control blocks. Results are returned through a start/done handshake.

---
 rtl/serial_rbs.sv | 130 +++++++++++++
 tb/tb_serial_rbs.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rbs.sv
// Bit-serial ripple-borrow subtractor: in1 - in2 - borrow_in, one bit per clock, start/done handshake.
// Optional signed-overflow output ovf is enabled by defining SERIAL_RBS_OVF_EN.
module serial_rbs #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic         borrow_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] diff,
   output logic         borrow_out
`ifdef SERIAL_RBS_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t          state_r;
   logic [N-1:0]    a_r;
   logic [N-1:0]    b_r;
   logic [N-1:0]    diff_r;
   logic            br_r;
   logic [CW-1:0]   cnt_r;
   logic            busy_r;
   logic            done_r;
   logic            borrow_out_r;
   logic            d_s;
   logic            bo_s;
`ifdef SERIAL_RBS_OVF_EN
   logic            ovf_r;
`endif

   function automatic logic fs_diff(input logic a, input logic b, input logic bi);
      return a ^ b ^ bi;
   endfunction

   function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
      return (~a & b) | (~(a ^ b) & bi);
   endfunction

   // Full-subtractor cell on the current LSBs and the running borrow
   always_comb begin
      d_s  = fs_diff(a_r[0], b_r[0], br_r);
      bo_s = fs_borrow(a_r[0], b_r[0], br_r);
   end

   // Control FSM and serial datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         a_r          <= '0;
         b_r          <= '0;
         diff_r       <= '0;
         br_r         <= 1'b0;
         cnt_r        <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         borrow_out_r <= 1'b0;
`ifdef SERIAL_RBS_OVF_EN
         ovf_r        <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_r     <= in1;
                  b_r     <= in2;
                  br_r    <= borrow_in;
                  cnt_r   <= '0;
                  diff_r  <= '0;
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            RUN: begin
               a_r    <= {1'b0, a_r[N-1:1]};
               b_r    <= {1'b0, b_r[N-1:1]};
               diff_r <= {d_s, diff_r[N-1:1]};
               br_r   <= bo_s;
               cnt_r  <= cnt_r + CW'(1);
               // This edge consumes the MSB: publish the final borrow and finish
               if (cnt_r == CW'(N - 1)) begin
                  borrow_out_r <= bo_s;
`ifdef SERIAL_RBS_OVF_EN
                  ovf_r        <= (a_r[0] != b_r[0]) && (d_s != a_r[0]);
`endif
                  done_r       <= 1'b1;
                  state_r      <= DONE;
               end else begin
                  done_r       <= 1'b0;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign diff       = diff_r;
   assign borrow_out = borrow_out_r;
`ifdef SERIAL_RBS_OVF_EN
   assign ovf        = ovf_r;
`endif

endmodule

// File: tb/tb_serial_rbs.sv
// Self-checking bench for serial_rbs: scoreboard of expected results popped on each done pulse.
module tb_serial_rbs;

   localparam int N = 4;

   typedef struct {
      logic [N-1:0] diff;
      logic         bo;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] in1 = '0;
   logic [N-1:0] in2 = '0;
   logic         borrow_in = 1'b0;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic         borrow_out;
`ifdef SERIAL_RBS_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;
   int done_count = 0;
   exp_t sb[$];

   serial_rbs #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in1        (in1),
      .in2        (in2),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_RBS_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Reference: (N+1)-bit unsigned subtraction, signed overflow from operand/result signs
   function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
      exp_t e;
      logic [N:0] r;
      r = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
      e.diff = r[N-1:0];
      e.bo   = r[N];
      e.ovf  = (x[N-1] != y[N-1]) && (r[N-1] != x[N-1]);
      return e;
   endfunction

   // Scoreboard: every done pulse pops and compares one expected result
   always @(negedge clk) begin
      if (done === 1'b1) begin
         exp_t e;
         done_count++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done=1 with empty scoreboard, diff=%h", diff);
         end else begin
            e = sb.pop_front();
            if (diff !== e.diff || borrow_out !== e.bo) begin
               errors++;
               $display("FAIL result: diff=%h borrow_out=%b, expected diff=%h borrow_out=%b",
                        diff, borrow_out, e.diff, e.bo);
            end
`ifdef SERIAL_RBS_OVF_EN
            checks++;
            if (ovf !== e.ovf) begin
               errors++;
               $display("FAIL ovf: got %b expected %b (diff=%h)", ovf, e.ovf, diff);
            end
`endif
         end
      end
   end

   // Launch one operation from IDLE, wait for its done, return to IDLE
   task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi, input exp_t e);
      bit seen;
      in1 = x; in2 = y; borrow_in = bi; start = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < N + 4 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL timeout: no done for in1=%h in2=%h bi=%b", x, y, bi);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; in1 = 4'h9; in2 = 4'h3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'h0 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b diff=%h bo=%b, expected all 0", busy, done, diff, borrow_out);
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      exp_t e;
      e = model(4'h9, 4'h3, 1'b0);
      e.diff = 4'h6; e.bo = 1'b0;
      in1 = 4'h9; in2 = 4'h3; borrow_in = 1'b0; start = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i <= N; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || done !== (i == N)) begin
            errors++;
            $display("FAIL latency[%0d]: busy=%b done=%b, expected busy=1 done=%b", i, busy, done, (i == N));
         end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL latency_end: busy=%b done=%b, expected 0 0", busy, done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      exp_t e;
      e = model(4'h3, 4'h9, 1'b0); e.diff = 4'hA; e.bo = 1'b1;
      launch(4'h3, 4'h9, 1'b0, e);
      e = model(4'h0, 4'h0, 1'b1); e.diff = 4'hF; e.bo = 1'b1;
      launch(4'h0, 4'h0, 1'b1, e);
      e = model(4'hF, 4'hF, 1'b1); e.diff = 4'hF; e.bo = 1'b1;
      launch(4'hF, 4'hF, 1'b1, e);
   endtask

   task automatic test_sweep();
      logic [N-1:0] x;
      logic [N-1:0] y;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            for (int k = 0; k < 2; k++) begin
               x = N'(i); y = N'(j);
               launch(x, y, k[0], model(x, y, k[0]));
            end
   endtask

   task automatic test_back_to_back();
      int base;
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic bi;
      base = done_count;
      for (int t = 0; t < 3; t++) begin
         x = N'($urandom_range(0, 15)); y = N'($urandom_range(0, 15)); bi = 1'($urandom_range(0, 1));
         in1 = x; in2 = y; borrow_in = bi; start = 1'b1;
         sb.push_back(model(x, y, bi));
         @(posedge clk);
         for (int c = 0; c < N + 1; c++) begin
            #1;
            in1 = ~x ^ N'($urandom_range(0, 15)); in2 = ~y; borrow_in = ~bi;
            @(posedge clk);
         end
         #1;
      end
      start = 1'b0;
      repeat (2) @(posedge clk); #1;
      checks++;
      if (done_count - base !== 3) begin
         errors++;
         $display("FAIL back_to_back_count: %0d done pulses, expected 3", done_count - base);
      end
   endtask

   task automatic test_reset_mid_run();
      int base;
      base = done_count;
      in1 = 4'h0; in2 = 4'h1; borrow_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'h0 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL mid_run_reset: busy=%b done=%b diff=%h bo=%b, expected all 0", busy, done, diff, borrow_out);
      end
      rst_n = 1'b1;
      repeat (N + 3) @(posedge clk); #1;
      checks++;
      if (done_count !== base) begin
         errors++;
         $display("FAIL mid_run_no_done: %0d done pulses after abort, expected 0", done_count - base);
      end
      launch(4'hC, 4'h5, 1'b1, model(4'hC, 4'h5, 1'b1));
   endtask

`ifdef SERIAL_RBS_OVF_EN
   task automatic test_ovf();
      exp_t e;
      e.diff = 4'h8; e.bo = 1'b1; e.ovf = 1'b1;
      launch(4'h7, 4'hF, 1'b0, e);
      e.diff = 4'h7; e.bo = 1'b0; e.ovf = 1'b1;
      launch(4'h8, 4'h1, 1'b0, e);
      e.diff = 4'h3; e.bo = 1'b0; e.ovf = 1'b0;
      launch(4'h5, 4'h2, 1'b0, e);
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_directed();
      test_sweep();
      test_back_to_back();
      test_reset_mid_run();
`ifdef SERIAL_RBS_OVF_EN
      test_ovf();
`endif
      repeat (2) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d results never produced, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
